// File: rtl/ifu_pc.sv
// Instruction-fetch PC unit: program counter, next-PC selection and fetch-address checking.
// Optional fetch counter enabled by defining IFU_FETCH_CNT_EN.
module ifu_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IM_AW    = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [15:0]      br_offset,
    input  logic             jump,
    input  logic [25:0]      j_index,
    input  logic             jr,
    input  logic [31:0]      jr_target,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [IM_AW-1:0] im_addr,
    output logic             fetch_valid,
    output logic             addr_err
`ifdef IFU_FETCH_CNT_EN
    ,
    output logic [31:0]      fetch_cnt
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        fetch_valid_q;
    logic        addr_err_q;

    logic [31:0] br_target;
    logic [31:0] next_pc_d;
    logic        next_legal;
    logic [32:0] addr_ext;
    logic [32:0] lo_bound;
    logic [32:0] hi_bound;
    logic [31:0] pc_off;
    logic        unused_pc_off;

    assign pc_plus4  = pc_q + 32'd4;
    assign br_target = pc_plus4 + {{14{br_offset[15]}}, br_offset, 2'b00};

    always_comb begin
        next_pc_d = pc_plus4;
        if (jr) begin
            next_pc_d = jr_target;
        end else if (jump) begin
            next_pc_d = {pc_plus4[31:28], j_index, 2'b00};
        end else if (br_taken) begin
            next_pc_d = br_target;
        end
    end

    // Bounds are widened to 33 bits so RESET_PC + memory size cannot wrap past 2^32.
    assign addr_ext   = {1'b0, next_pc_d};
    assign lo_bound   = {1'b0, RESET_PC};
    assign hi_bound   = lo_bound + (33'd4 << IM_AW);
    assign next_legal = (next_pc_d[1:0] == 2'b00) && (addr_ext >= lo_bound) && (addr_ext < hi_bound);

    assign pc_off        = pc_q - RESET_PC;
    assign im_addr       = pc_off[IM_AW+1:2];
    assign unused_pc_off = ^{pc_off[31:IM_AW+2], pc_off[1:0]};

    assign pc          = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign addr_err    = addr_err_q;

`ifdef IFU_FETCH_CNT_EN
    logic [31:0] fetch_cnt_q;
    assign fetch_cnt = fetch_cnt_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
`ifdef IFU_FETCH_CNT_EN
            fetch_cnt_q   <= 32'd0;
`endif
        end else begin
            case (state_q)
                BOOT: begin
                    state_q       <= RUN;
                    fetch_valid_q <= 1'b1;
                end
                RUN: begin
                    // stall overrides every redirect, including an illegal one.
                    if (!stall) begin
                        if (next_legal) begin
                            pc_q <= next_pc_d;
`ifdef IFU_FETCH_CNT_EN
                            fetch_cnt_q <= fetch_cnt_q + 32'd1;
`endif
                        end else begin
                            state_q       <= HALT;
                            fetch_valid_q <= 1'b0;
                            addr_err_q    <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    fetch_valid_q <= 1'b0;
                    addr_err_q    <= 1'b1;
                end
                default: begin
                    state_q       <= HALT;
                    fetch_valid_q <= 1'b0;
                    addr_err_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_pc.sv
// Directed bench for ifu_pc: reset/boot, sequential fetch, redirects, stall,
// illegal-address halt, asynchronous reset, and running off the end of memory.
module tb_ifu_pc;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_offset;
    logic        jump;
    logic [25:0] j_index;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [11:0] im_addr;
    logic        fetch_valid;
    logic        addr_err;
`ifdef IFU_FETCH_CNT_EN
    logic [31:0] fetch_cnt;
`endif

    int total = 0;
    int bad   = 0;

    ifu_pc #(.RESET_PC(32'h0000_3000), .IM_AW(12)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_offset   (br_offset),
        .jump        (jump),
        .j_index     (j_index),
        .jr          (jr),
        .jr_target   (jr_target),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .im_addr     (im_addr),
        .fetch_valid (fetch_valid),
        .addr_err    (addr_err)
`ifdef IFU_FETCH_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; br_taken = 0; br_offset = '0; jump = 0; j_index = '0; jr = 0; jr_target = '0;
    endtask

    task automatic chk_pc(input string tag, input logic [31:0] exp_pc, input logic exp_fv, input logic exp_err);
        chk({tag, ".pc"}, pc, exp_pc);
        chk({tag, ".im"}, {20'd0, im_addr}, (exp_pc - 32'h3000) >> 2);
        chk({tag, ".fv"}, {31'd0, fetch_valid}, {31'd0, exp_fv});
        chk({tag, ".err"}, {31'd0, addr_err}, {31'd0, exp_err});
    endtask

    initial begin
        idle();
        reset = 0;
        #12;
        chk_pc("rst", 32'h3000, 1'b0, 1'b0);
        chk("rst.p4", pc_plus4, 32'h3004);
`ifdef IFU_FETCH_CNT_EN
        chk("rst.cnt", fetch_cnt, 32'd0);
`endif
        @(negedge clk);
        reset = 1;
        #1;
        chk_pc("boot", 32'h3000, 1'b0, 1'b0);

        // Sequential fetch after release
        tick(); chk_pc("seq1", 32'h3000, 1'b1, 1'b0);
        tick(); chk_pc("seq2", 32'h3004, 1'b1, 1'b0);
        tick(); chk_pc("seq3", 32'h3008, 1'b1, 1'b0);
        tick(); chk_pc("seq4", 32'h300C, 1'b1, 1'b0);
        tick(); chk_pc("seq5", 32'h3010, 1'b1, 1'b0);

        // Backward branch
        br_taken = 1; br_offset = 16'hFFFC;
        tick(); chk_pc("br_neg", 32'h3004, 1'b1, 1'b0);
        idle();
        tick(); tick(); tick(); chk_pc("back3010", 32'h3010, 1'b1, 1'b0);
        br_taken = 1; br_offset = 16'h0003;
        tick(); chk_pc("br_pos", 32'h3020, 1'b1, 1'b0);

        // All redirects together: jr wins, then jump beats branch
        jr = 1; jr_target = 32'h3100; jump = 1; j_index = 26'h0C00; br_taken = 1; br_offset = 16'h0001;
        tick(); chk_pc("jr_win", 32'h3100, 1'b1, 1'b0);
        jr = 0;
        tick(); chk_pc("jmp_win", 32'h3000, 1'b1, 1'b0);
        chk("jmp.p4", pc_plus4, 32'h3004);

        // Stall holds PC against a pending jump
        idle();
        jump = 1; j_index = 26'h0C40; stall = 1;
        tick(); chk_pc("stall1", 32'h3000, 1'b1, 1'b0);
        tick(); chk_pc("stall2", 32'h3000, 1'b1, 1'b0);
        tick(); chk_pc("stall3", 32'h3000, 1'b1, 1'b0);
        stall = 0;
        tick(); chk_pc("unstall", 32'h3100, 1'b1, 1'b0);

        // Highest legal word is accepted
        idle();
        jr = 1; jr_target = 32'h0000_6FFC;
        tick(); chk_pc("jr_top", 32'h6FFC, 1'b1, 1'b0);
        jr_target = 32'h0000_3100;
        tick(); chk_pc("jr_back", 32'h3100, 1'b1, 1'b0);

        // Misaligned target halts
        jr_target = 32'h0000_3002;
        tick(); chk_pc("misal", 32'h3100, 1'b0, 1'b1);
        jr_target = 32'h0000_3200;
        for (int i = 0; i < 5; i++) begin
            jump = i[0]; br_taken = 1; br_offset = 16'h0004;
            tick();
        end
        chk_pc("halt_hold", 32'h3100, 1'b0, 1'b1);

        // Asynchronous reset mid-cycle
        @(negedge clk);
        #2;
        reset = 0;
        #1;
        chk_pc("areset", 32'h3000, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        reset = 1;
        tick(); chk_pc("reboot", 32'h3000, 1'b1, 1'b0);

        // Below-base and one-past-end targets are illegal
        jr = 1; jr_target = 32'h0000_2FFC;
        tick(); chk_pc("below", 32'h3000, 1'b0, 1'b1);
        idle();
        reset = 0; #1;
        @(negedge clk); reset = 1;
        tick();
        jr = 1; jr_target = 32'h0000_7000;
        tick(); chk_pc("pastend", 32'h3000, 1'b0, 1'b1);

        // Run off the end of instruction memory
        idle();
        reset = 0; #1;
        @(negedge clk); reset = 1;
        tick(); chk_pc("run0", 32'h3000, 1'b1, 1'b0);
        for (int i = 0; i < 4095; i++) tick();
        chk_pc("lastword", 32'h6FFC, 1'b1, 1'b0);
`ifdef IFU_FETCH_CNT_EN
        chk("cnt_last", fetch_cnt, 32'd4095);
`endif
        tick(); chk_pc("falloff", 32'h6FFC, 1'b0, 1'b1);
        tick(); chk_pc("falloff2", 32'h6FFC, 1'b0, 1'b1);
`ifdef IFU_FETCH_CNT_EN
        chk("cnt_frozen", fetch_cnt, 32'd4095);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
